// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the 2x2 pooling stream sequencer.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    // Counter/index width for a range of n values, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_N_DEFAULT = 4;
    localparam int CH_W         = cntWidth(CH_N_DEFAULT);

endpackage

// File: rtl/pool_addr_gen.sv
// Column/row/channel walker with a running read pointer for row-major feature maps.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int CH_N   = 4,
    parameter int ADDR_W = 16,
    parameter int CHW    = cntWidth(CH_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              adv_i,
    input  logic              nextCh_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CHW-1:0]    ch_o,
    output logic              lastCol_o,
    output logic              lastPix_o,
    output logic              lastCh_o,
    output logic              winTag_o
);

    localparam int COL_W = cntWidth(IMG_W);
    localparam int ROW_W = cntWidth(IMG_H);

    logic [COL_W-1:0]  colQ, colD;
    logic [ROW_W-1:0]  rowQ, rowD;
    logic [CHW-1:0]    chQ, chD;
    logic [ADDR_W-1:0] ptrQ, ptrD;
    logic              lastRow;

    assign lastCol_o = (colQ == COL_W'(IMG_W - 1));
    assign lastRow   = (rowQ == ROW_W'(IMG_H - 1));
    assign lastPix_o = lastCol_o && lastRow;
    assign lastCh_o  = (chQ == CHW'(CH_N - 1));
    // Odd trailing column/row have even indices, so they never tag a window.
    assign winTag_o  = rowQ[0] & colQ[0];
    assign addr_o    = ptrQ;
    assign ch_o      = chQ;

    // The pointer just counts issued reads; channel planes are contiguous,
    // so stepping to the next channel needs no address adjustment.
    always_comb begin
        colD = colQ;
        rowD = rowQ;
        chD  = chQ;
        ptrD = ptrQ;
        if (init_i) begin
            colD = '0;
            rowD = '0;
            chD  = '0;
            ptrD = base_i;
        end else if (adv_i) begin
            ptrD = ptrQ + ADDR_W'(1);
            if (lastCol_o) begin
                colD = '0;
                rowD = lastRow ? '0 : rowQ + ROW_W'(1);
            end else begin
                colD = colQ + COL_W'(1);
            end
        end else if (nextCh_i) begin
            chD  = chQ + CHW'(1);
            colD = '0;
            rowD = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            colQ <= '0;
            rowQ <= '0;
            chQ  <= '0;
            ptrQ <= '0;
        end else begin
            colQ <= colD;
            rowQ <= rowD;
            chQ  <= chD;
            ptrQ <= ptrD;
        end
    end

endmodule

// File: rtl/pool_stream_ctrl.sv
// Sequencer streaming a multi-channel feature map from SRAM into the 2x2 pooling line buffer.
module pool_stream_ctrl
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int CH_N   = 4,
    parameter int ADDR_W = 16,
    localparam int CHW   = cntWidth(CH_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              lb_rst,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_win,
    output logic [CHW-1:0]    ch_idx,
    output logic              busy,
    output logic              done
);

    state_e stateQ, stateD;

    logic           init, adv, nextCh;
    logic           lastCol, lastPix, lastCh, winTag;
    logic [CHW-1:0] ch;
    logic           pixValidQ, pixWinQ;
    logic [CHW-1:0] chIdxQ;

    pool_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .CH_N   (CH_N),
        .ADDR_W (ADDR_W),
        .CHW    (CHW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .init_i    (init),
        .adv_i     (adv),
        .nextCh_i  (nextCh),
        .base_i    (base_addr),
        .addr_o    (rd_addr),
        .ch_o      (ch),
        .lastCol_o (lastCol),
        .lastPix_o (lastPix),
        .lastCh_o  (lastCh),
        .winTag_o  (winTag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // DRAIN separates the final read of a channel from the next clear so the
    // in-flight pixel lands in the line buffer before it is wiped.
    always_comb begin
        stateD = stateQ;
        init   = 1'b0;
        adv    = 1'b0;
        nextCh = 1'b0;
        rd_en  = 1'b0;
        lb_rst = 1'b0;
        done   = 1'b0;
        busy   = 1'b1;
        unique case (stateQ)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    init   = 1'b1;
                    stateD = CLEAR;
                end
            end
            CLEAR: begin
                lb_rst = 1'b1;
                stateD = STREAM;
            end
            STREAM: begin
                rd_en = out_ready;
                adv   = out_ready;
                if (out_ready && lastPix) begin
                    stateD = DRAIN;
                end
            end
            DRAIN: begin
                if (lastCh) begin
                    stateD = DONE;
                end else begin
                    nextCh = 1'b1;
                    stateD = CLEAR;
                end
            end
            DONE: begin
                done   = 1'b1;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    // One-cycle delay of the read strobe and its tags to line up with rd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixValidQ <= 1'b0;
            pixWinQ   <= 1'b0;
            chIdxQ    <= '0;
        end else begin
            pixValidQ <= rd_en;
            pixWinQ   <= rd_en & winTag;
            if (rd_en) begin
                chIdxQ <= ch;
            end
        end
    end

    assign pix_valid = pixValidQ;
    assign pix_win   = pixWinQ;
    assign ch_idx    = chIdxQ;
    assign pix_data  = pixValidQ ? rd_data : '0;

    logic unusedLastCol;
    assign unusedLastCol = lastCol;

endmodule

// File: doc/pool_stream_ctrl.md
# pool_stream_ctrl

Sequencer for the 2×2 pooling stage. It walks a CH_N-channel feature map stored row-major in on-chip memory and streams pixels one per cycle into the 2×2 window line buffer. It clears that line buffer before each channel and tags the pixels that complete a stride-2 window, so the pool unit knows which windows to keep. It sits between the feature-map SRAM read port and the line-buffer/pool datapath.

## Interface
- DATA_W, 8, pixel width (signed)
- IMG_W, 8, feature-map width in pixels (≥2)
- IMG_H, 8, feature-map height in pixels (≥2)
- CH_N, 4, channels per frame (≥1)
- ADDR_W, 16, memory address width
- Reset is rst, synchronous, active-high; clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- base_addr  in  ADDR_W  address of channel 0 pixel (0,0); latched on accepted start
- out_ready  in  1  downstream can accept issuance of a new pixel
- rd_data  in  DATA_W  memory read data; valid exactly 1 cycle after rd_en
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory read address
- lb_rst  out  1  line-buffer clear, one-cycle pulse per channel
- pix_valid  out  1  pix_data valid (feeds line buffer in_valid)
- pix_data  out  DATA_W  pixel, equal to rd_data passed through
- pix_win  out  1  pixel completes a stride-2 window (odd row AND odd col); qualified by pix_valid
- ch_idx  out  clog2(CH_N) (min 1)  channel of the current pix_valid beat
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- States:
  - IDLE: start=1 → latch base_addr, zero col/row/ch → CLEAR.
  - CLEAR: lb_rst=1 for one cycle → STREAM.
  - STREAM: issues rd_en when out_ready=1 and advances col. col wraps IMG_W-1→0 and increments row. On the last pixel of a channel (row=IMG_H-1, col=IMG_W-1, issued) → DRAIN.
  - DRAIN: one cycle, so the in-flight last pixel lands before any clear. If ch<CH_N-1: increment ch, zero row/col → CLEAR. Otherwise → DONE.
  - DONE: done=1 for one cycle → IDLE.
- rd_addr = base + ch·IMG_W·IMG_H + row·IMG_W + col. It is implemented as a running pointer incremented per issued read, with no multiplier. Address arithmetic wraps modulo 2^ADDR_W.
- out_ready=0 in STREAM: no rd_en, and counters hold. A read issued in the previous cycle still produces its pix_valid beat; downstream must absorb that one beat.
- pix_valid, pix_win and ch_idx are registered copies of rd_en and its window tag, delayed by 1 cycle so they align with rd_data.
- Odd IMG_W/IMG_H: the trailing column/row is never tagged pix_win (floor pooling).
- start while busy: ignored. start held high in IDLE after DONE: a new frame begins.
- rst at any time: return to IDLE immediately. Any in-flight beat is discarded.

## Timing
- Reset values: rd_en=0, rd_addr=0, lb_rst=0, pix_valid=0, pix_data=0, pix_win=0, ch_idx=0, busy=0, done=0.
- start high in cycle 0 → lb_rst in cycle 1 → first rd_en in cycle 2 → first pix_valid in cycle 3.
- With out_ready held high, each channel takes 1 + IMG_W·IMG_H + 1 cycles. done pulses CH_N·(IMG_W·IMG_H+2)+1 cycles after the start cycle; 8×8×4 gives cycle 265.
- Each stalled cycle adds exactly one cycle to the total.
- lb_rst is never high in the same cycle as pix_valid.

## Structure
- Shared package pool_pkg holds:
  - state enum {IDLE, CLEAR, STREAM, DRAIN, DONE};
  - CH_W = clog2(CH_N) with a minimum of 1.
- Sub-module pool_addr_gen holds the col/row/ch counters and the running address pointer. It outputs the last-col, last-pixel and window-tag flags. The FSM and output pipeline stay in the top level.

## Test plan
- 8×8×4, base 0x0100, out_ready=1 → 256 reads at 0x0100..0x01FF in order; 64 pix_win beats (16 per channel); 4 lb_rst pulses; done at cycle 265.
- out_ready toggled 1,0 every cycle during channel 0 → pix_data order unchanged, no read lost or duplicated; done delayed by exactly the number of stalled cycles.
- IMG_W=5, IMG_H=3, CH_N=1 → pix_win only at (1,1) and (1,3); no tag in column 4 or row 2.
- start pulsed while busy, plus rst asserted mid-channel 2 → busy=0 and all outputs at reset values next cycle; a later start restarts from channel 0 at the new base_addr.
- base_addr=0xFFF0, 8×8×1 → rd_addr wraps 0xFFFF→0x0000 after 16 reads; done pulses normally.
